// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared vertical timing types and 1024x768@60 constants
// Contents: v_state_t enum, vertical span defaults, derived total and sync
// start/end lines, and a helper that maps a line index to its vertical region.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } v_state_t;

    localparam int V_ACTIVE_DEF      = 768;
    localparam int V_FRONT_PORCH_DEF = 3;
    localparam int V_SYNC_WIDTH_DEF  = 6;
    localparam int V_BACK_PORCH_DEF  = 29;
    localparam bit V_SYNC_POL_DEF    = 1'b0;
    localparam int COUNTER_WIDTH_DEF = 11;

    localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FRONT_PORCH_DEF
                                    + V_SYNC_WIDTH_DEF + V_BACK_PORCH_DEF;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FRONT_PORCH_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_WIDTH_DEF;

    // Region is a pure function of the line index, so a zero-length span is
    // never selected and the FSM passes through it within the same edge.
    function automatic v_state_t v_region(input int line, input int active,
                                          input int sync_start, input int sync_end);
        v_state_t r;
        if (line < active)
            r = ACTIVE;
        else if (line < sync_start)
            r = FRONT;
        else if (line < sync_end)
            r = SYNC;
        else
            r = BACK;
        return r;
    endfunction

endpackage

// File: rtl/v_line_counter.sv
// rtl/v_line_counter.sv - enable/strobe-qualified line counter with wrap flag
// Ports: clk, rst_n (async active-low), enable, strobe in; count (registered),
// next_count (value after the next counted strobe), step (counted strobe this
// cycle), wrap (counted strobe on the last line) out.
module v_line_counter #(
    parameter int WIDTH = 11,
    parameter int TOTAL = 806
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             strobe,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next_count,
    output logic             step,
    output logic             wrap
);

    logic at_last;

    always_comb begin
        at_last    = (count == WIDTH'(TOTAL - 1));
        step       = enable & strobe;
        wrap       = step & at_last;
        next_count = at_last ? '0 : count + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (step)
            count <= next_count;
    end

    a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= WIDTH'(TOTAL - 1));

endmodule

// File: rtl/v_sync_generator.sv
// rtl/v_sync_generator.sv - vertical timing stage driven by the H-stage line_end strobe
// Ports: control_clock, control_reset_n (async active-low), enable, line_end in;
// line_count, v_sync, v_active, frame_start, frame_end out.
// FRAME_COUNTER_EN: when defined adds frame_count[7:0], incremented on each frame_start.
module v_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int V_ACTIVE      = V_ACTIVE_DEF,
    parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
    parameter int V_SYNC_WIDTH  = V_SYNC_WIDTH_DEF,
    parameter int V_BACK_PORCH  = V_BACK_PORCH_DEF,
    parameter bit V_SYNC_POL    = V_SYNC_POL_DEF,
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF
) (
    input  logic                     control_clock,
    input  logic                     control_reset_n,
    input  logic                     enable,
    input  logic                     line_end,
    output logic [COUNTER_WIDTH-1:0] line_count,
    output logic                     v_sync,
    output logic                     v_active,
    output logic                     frame_start,
`ifdef FRAME_COUNTER_EN
    output logic                     frame_end,
    output logic [7:0]               frame_count
`else
    output logic                     frame_end
`endif
);

    localparam int V_TOTAL      = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int V_SYNC_START = V_ACTIVE + V_FRONT_PORCH;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_WIDTH;

    logic [COUNTER_WIDTH-1:0] next_count;
    logic                     step;
    logic                     wrap;
    v_state_t                 state;
    v_state_t                 next_state;

    v_line_counter #(
        .WIDTH (COUNTER_WIDTH),
        .TOTAL (V_TOTAL)
    ) u_line_counter (
        .clk        (control_clock),
        .rst_n      (control_reset_n),
        .enable     (enable),
        .strobe     (line_end),
        .count      (line_count),
        .next_count (next_count),
        .step       (step),
        .wrap       (wrap)
    );

    always_comb begin
        next_state = v_region(int'(next_count), V_ACTIVE, V_SYNC_START, V_SYNC_END);
    end

    // Pulses clear on every edge that is not a counted strobe, so they stay
    // single-cycle even when line_end is held or enable drops right after.
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            state       <= ACTIVE;
            v_active    <= 1'b1;
            v_sync      <= ~V_SYNC_POL;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (step) begin
                state       <= next_state;
                v_active    <= (next_state == ACTIVE);
                v_sync      <= (next_state == SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
                frame_end   <= (state == ACTIVE) && (next_state != ACTIVE);
                frame_start <= wrap;
            end
        end
    end

`ifdef FRAME_COUNTER_EN
    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n)
            frame_count <= 8'd0;
        else if (wrap)
            frame_count <= frame_count + 8'd1;
    end
`endif

endmodule
